layer0_input_packer: RTL and testbench

Front-end stage that feeds the layer-0 LUT neuron array of the LogicNet classifier. It accepts raw signed feature words one per beat, quantizes each to IN_BITS unsigned bits and packs a full frame into one flat input vector. It presents that vector to the layer-0 fan-out with a valid/ready handshake. It also checks frame length and discards malformed frames.

---
 rtl/layer0_input_packer.sv | 158 +++++++++++++++
 tb/tb_layer0_input_packer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/layer0_input_packer.sv
// Layer-0 input packer: quantizes raw signed feature beats to IN_BITS each,
// packs a full frame into one vector and hands it to layer 0 via valid/ready.
module layer0_input_packer #(
    parameter int NUM_FEAT = 32,
    parameter int FEAT_W   = 16,
    parameter int IN_BITS  = 2,
    parameter int SHIFT    = 12,
    parameter int BIAS     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FEAT_W-1:0]           s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    output logic                        s_ready,
    output logic [NUM_FEAT*IN_BITS-1:0] m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        frame_err,
    output logic [7:0]                  err_cnt
);

    // state | meaning
    // FILL  | collecting features of the current frame into the fill buffer
    // HOLD  | complete frame parked in the fill buffer, output slot busy
    // DROP  | long frame detected, swallowing beats until s_last
    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam int DW    = NUM_FEAT * IN_BITS;
    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
    localparam logic signed [FEAT_W:0] QMAX = (FEAT_W+1)'((2 ** IN_BITS) - 1);
    localparam logic signed [FEAT_W:0] QBIAS = (FEAT_W+1)'(BIAS);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    fill_q, fill_d;
    logic [DW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic               beat;
    logic               slot_free;
    logic [IN_BITS-1:0] q_feat;
    logic [DW-1:0]      wr_vec;
    logic               err;

    // Widen by one bit so the bias add can never overflow before saturation.
    function automatic logic [IN_BITS-1:0] quant(input logic [FEAT_W-1:0] raw);
        logic signed [FEAT_W:0] ext;
        logic signed [FEAT_W:0] y;
        ext = $signed({raw[FEAT_W-1], raw});
        y   = (ext >>> SHIFT) + QBIAS;
        if (y[FEAT_W])
            quant = '0;
        else if (y > QMAX)
            quant = '1;
        else
            quant = y[IN_BITS-1:0];
    endfunction

    assign s_ready   = rst && (state_q != ST_HOLD);
    assign beat      = s_valid && s_ready;
    assign slot_free = !m_valid_q || m_ready;
    assign q_feat    = quant(s_data);

    always_comb begin
        wr_vec = fill_q;
        wr_vec[int'(idx_q)*IN_BITS +: IN_BITS] = q_feat;
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        fill_d   = fill_q;
        m_data_d = m_data_q;
        err      = 1'b0;
        m_valid_d = m_valid_q && !m_ready;

        case (state_q)
            ST_FILL: begin
                if (beat) begin
                    if (idx_q != LAST_IDX) begin
                        if (s_last) begin
                            err   = 1'b1;
                            idx_d = '0;
                        end else begin
                            fill_d = wr_vec;
                            idx_d  = idx_q + 1'b1;
                        end
                    end else if (s_last) begin
                        idx_d = '0;
                        if (slot_free) begin
                            m_data_d  = wr_vec;
                            m_valid_d = 1'b1;
                        end else begin
                            fill_d  = wr_vec;
                            state_d = ST_HOLD;
                        end
                    end else begin
                        err     = 1'b1;
                        idx_d   = '0;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_HOLD: begin
                if (slot_free) begin
                    m_data_d  = fill_q;
                    m_valid_d = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_DROP: begin
                if (beat && s_last) begin
                    idx_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = ST_FILL;
            end
        endcase

        frame_err_d = err;
        err_cnt_d   = (err && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            fill_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_q      <= fill_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed bench for layer0_input_packer with NUM_FEAT=4, SHIFT=4, BIAS=2.
module tb_layer0_input_packer;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    layer0_input_packer #(
        .NUM_FEAT(4), .FEAT_W(16), .IN_BITS(2), .SHIFT(4), .BIAS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] d;
        logic        v;
        logic        l;
        logic        mr;
        logic        e_mv;
        logic [7:0]  e_md;
        logic        e_sr;
        logic        e_fe;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [15:0] d, logic v, logic l, logic mr,
                                logic e_mv, logic [7:0] e_md, logic e_sr,
                                logic e_fe, logic [7:0] e_cnt);
        vec_t t;
        t.rst = r; t.d = d; t.v = v; t.l = l; t.mr = mr;
        t.e_mv = e_mv; t.e_md = e_md; t.e_sr = e_sr; t.e_fe = e_fe; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // m_data is only meaningful while m_valid is expected high.
    task automatic chk_out(input string tag, input logic e_mv, input logic [7:0] e_md,
                           input logic e_sr, input logic e_fe, input logic [7:0] e_cnt);
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(e_mv));
        if (e_mv) chk({tag, ".m_data"}, 32'(m_data), 32'(e_md));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(e_sr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(e_fe));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled there too.
    task automatic step(input logic r, input logic [15:0] d, input logic v,
                        input logic l, input logic mr);
        rst = r; s_data = d; s_valid = v; s_last = l; m_ready = mr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;

        // reset, then idle
        tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 8'h00, 0, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        // quantizer frame -> 00_01_10_11
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'hFFF0, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'hFF00, 1, 1, 1, 1, 8'h1B, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        // saturation frame 7FFF,8000,0000,0010 -> 11_10_00_11
        tbl.push_back(mk(1, 16'h7FFF, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h8000, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0010, 1, 1, 1, 1, 8'hE3, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        // short frame: s_last on beat 2
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd0));
        tbl.push_back(mk(1, 16'h0000, 1, 1, 1, 0, 8'h00, 1, 1, 8'd1));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        // good frame FF00,FFF0,0000,0010 -> 11_10_01_00
        tbl.push_back(mk(1, 16'hFF00, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'hFFF0, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0000, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0010, 1, 1, 1, 1, 8'hE4, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        // long frame: 6 beats, error flagged at beat 4, beats 5-6 dropped
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd1));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 1, 8'd2));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd2));
        tbl.push_back(mk(1, 16'h0010, 1, 1, 1, 0, 8'h00, 1, 0, 8'd2));
        // following good frame, all 0x0010 -> 0xFF
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd2));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd2));
        tbl.push_back(mk(1, 16'h0010, 1, 0, 1, 0, 8'h00, 1, 0, 8'd2));
        tbl.push_back(mk(1, 16'h0010, 1, 1, 1, 1, 8'hFF, 1, 0, 8'd2));
        tbl.push_back(mk(1, 16'h0000, 0, 0, 1, 0, 8'h00, 1, 0, 8'd2));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].mr);
            chk_out($sformatf("vec%0d", i), tbl[i].e_mv, tbl[i].e_md,
                    tbl[i].e_sr, tbl[i].e_fe, tbl[i].e_cnt);
        end

        // Backpressure: frame A shows up and is held, frame B parks in HOLD.
        step(1, 16'h0010, 1, 0, 0); chk_out("bp.a1", 0, 8'h00, 1, 0, 8'd2);
        step(1, 16'h0000, 1, 0, 0); chk_out("bp.a2", 0, 8'h00, 1, 0, 8'd2);
        step(1, 16'hFFF0, 1, 0, 0); chk_out("bp.a3", 0, 8'h00, 1, 0, 8'd2);
        step(1, 16'hFF00, 1, 1, 0); chk_out("bp.a4", 1, 8'h1B, 1, 0, 8'd2);
        step(1, 16'hFF00, 1, 0, 0); chk_out("bp.b1", 1, 8'h1B, 1, 0, 8'd2);
        step(1, 16'hFFF0, 1, 0, 0); chk_out("bp.b2", 1, 8'h1B, 1, 0, 8'd2);
        step(1, 16'h0000, 1, 0, 0); chk_out("bp.b3", 1, 8'h1B, 1, 0, 8'd2);
        step(1, 16'h0010, 1, 1, 0); chk_out("bp.b4", 1, 8'h1B, 0, 0, 8'd2);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h7FFF, 1, 1, 0);
            chk_out($sformatf("bp.hold%0d", i), 1, 8'h1B, 0, 0, 8'd2);
        end
        step(1, 16'h0000, 0, 0, 1); chk_out("bp.xfer", 1, 8'hE4, 1, 0, 8'd2);
        step(1, 16'h0000, 0, 0, 0); chk_out("bp.keep", 1, 8'hE4, 1, 0, 8'd2);
        step(1, 16'h0000, 0, 0, 1); chk_out("bp.drain", 0, 8'h00, 1, 0, 8'd2);

        // Reset mid-frame after 2 beats, then a full frame packs from slot 0.
        step(1, 16'h7FFF, 1, 0, 1); chk_out("rst.b1", 0, 8'h00, 1, 0, 8'd2);
        step(1, 16'h7FFF, 1, 0, 1); chk_out("rst.b2", 0, 8'h00, 1, 0, 8'd2);
        step(0, 16'h7FFF, 1, 0, 1); chk_out("rst.assert", 0, 8'h00, 0, 0, 8'd0);
        step(1, 16'h0010, 1, 0, 1); chk_out("rst.f1", 0, 8'h00, 1, 0, 8'd0);
        step(1, 16'h0000, 1, 0, 1); chk_out("rst.f2", 0, 8'h00, 1, 0, 8'd0);
        step(1, 16'hFFF0, 1, 0, 1); chk_out("rst.f3", 0, 8'h00, 1, 0, 8'd0);
        step(1, 16'hFF00, 1, 1, 1); chk_out("rst.f4", 1, 8'h1B, 1, 0, 8'd0);
        step(1, 16'h0000, 0, 0, 1); chk_out("rst.idle", 0, 8'h00, 1, 0, 8'd0);

        // 300 one-beat short frames: counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            step(1, 16'h0010, 1, 1, 1);
            chk($sformatf("sat.cnt%0d", i), 32'(err_cnt), (i > 255) ? 32'd255 : 32'(i));
            chk($sformatf("sat.fe%0d", i), 32'(frame_err), 32'd1);
        end
        step(1, 16'h0000, 0, 0, 1); chk_out("sat.idle", 0, 8'h00, 1, 0, 8'd255);
        step(1, 16'hFF00, 1, 0, 1); chk_out("sat.g1", 0, 8'h00, 1, 0, 8'd255);
        step(1, 16'hFFF0, 1, 0, 1); chk_out("sat.g2", 0, 8'h00, 1, 0, 8'd255);
        step(1, 16'h0000, 1, 0, 1); chk_out("sat.g3", 0, 8'h00, 1, 0, 8'd255);
        step(1, 16'h0010, 1, 1, 1); chk_out("sat.g4", 1, 8'hE4, 1, 0, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
